// File: rtl/mips32_pkg.sv
// Shared MIPS32 pipeline definitions: opcodes, instruction type codes and field positions.
package mips32_pkg;

  localparam int WORD_W  = 32;
  localparam int OPC_MSB = 31;
  localparam int OPC_LSB = 26;

  typedef enum logic [5:0] {
    ADD   = 6'b000000,
    SUB   = 6'b000001,
    AND   = 6'b000010,
    OR    = 6'b000011,
    SLT   = 6'b000100,
    MUL   = 6'b000101,
    LW    = 6'b001000,
    SW    = 6'b001001,
    ADDI  = 6'b001010,
    SUBI  = 6'b001011,
    SLTI  = 6'b001100,
    BNEQZ = 6'b001101,
    BEQZ  = 6'b001110,
    HLT   = 6'b111111
  } opcode_e;

  typedef enum logic [2:0] {
    RR_ALU = 3'd0,
    RM_ALU = 3'd1,
    LOAD   = 3'd2,
    STORE  = 3'd3,
    BRANCH = 3'd4,
    HALT   = 3'd5
  } itype_e;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    STOP   = 2'd1,
    HALTED = 2'd2
  } fetch_state_e;

  function automatic logic is_hlt(input logic [WORD_W-1:0] w);
    return w[OPC_MSB:OPC_LSB] == HLT;
  endfunction

endpackage

// File: rtl/mips32_fetch_stage_if.sv
// Instruction-memory read port between the fetch stage (master) and the memory (slave).
interface mips32_fetch_stage_if
  import mips32_pkg::*;
#(
  parameter int IMEM_AW = 10
);
  logic               imem_req;
  logic [IMEM_AW-1:0] imem_addr;
  logic               imem_rvalid;
  logic [WORD_W-1:0]  imem_rdata;

  modport master (output imem_req, imem_addr, input imem_rvalid, imem_rdata);
  modport slave  (input imem_req, imem_addr, output imem_rvalid, imem_rdata);
endinterface

// File: rtl/mips32_fetch_fifo.sv
// Small synchronous queue holding {instruction, next-PC} pairs between IF and ID.
module mips32_fetch_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 64,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic             flush_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] head_o,
  output logic [CNT_W-1:0] count_o
);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] rd_q, rd_d, wr_q, wr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             do_push, do_pop;

  assign do_push = push_i && (cnt_q != CNT_W'(DEPTH));
  assign do_pop  = pop_i && (cnt_q != '0);

  // Pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    rd_d  = rd_q;
    wr_d  = wr_q;
    cnt_d = cnt_q;
    if (flush_i) begin
      rd_d  = '0;
      wr_d  = '0;
      cnt_d = '0;
    end else begin
      if (do_push) wr_d = wr_q + PTR_W'(1);
      if (do_pop)  rd_d = rd_q + PTR_W'(1);
      cnt_d = cnt_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      rd_q  <= rd_d;
      wr_q  <= wr_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush_i) mem_q[wr_q] <= wdata_i;
  end

  assign head_o  = mem_q[rd_q];
  assign count_o = cnt_q;

endmodule

// File: rtl/mips32_fetch_stage.sv
// MIPS32 IF stage: owns the PC, issues single-outstanding instruction reads and
// queues returned words for ID, with branch redirect and HLT handling.
module mips32_fetch_stage
  import mips32_pkg::*;
#(
  parameter logic [WORD_W-1:0] RESET_PC = 32'h0000_0000,
  parameter int                IMEM_AW  = 10,
  parameter int                DEPTH    = 2
) (
  input  logic                 clk1,
  input  logic                 rst_n,
  mips32_fetch_stage_if.master imem,
  input  logic                 br_taken,
  input  logic [WORD_W-1:0]    br_target,
  input  logic                 id_ready,
  output logic                 if_id_valid,
  output logic [WORD_W-1:0]    if_id_ir,
  output logic [WORD_W-1:0]    if_id_npc,
  output logic                 halted
);
  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam int OCC_W = CNT_W + 1;

  fetch_state_e        state_q, state_d;
  logic [WORD_W-1:0]   pc_q, pc_d, req_npc_q, req_npc_d;
  logic                outst_q, outst_d, drop_q, drop_d;
  logic                hlt_seen_q, hlt_seen_d, halted_q, halted_d;
  logic [CNT_W-1:0]    count;
  logic [2*WORD_W-1:0] head;
  logic [OCC_W-1:0]    occ;
  logic                redirect, rsp, push, pop, push_hlt, pop_hlt, issue;

  mips32_fetch_fifo #(.DEPTH(DEPTH), .WIDTH(2*WORD_W)) u_fifo (
    .clk     (clk1),
    .rst_n   (rst_n),
    .push_i  (push),
    .pop_i   (pop),
    .flush_i (redirect),
    .wdata_i ({imem.imem_rdata, req_npc_q}),
    .head_o  (head),
    .count_o (count)
  );

  assign if_id_valid    = (count != '0) && (state_q != HALTED);
  assign if_id_ir       = if_id_valid ? head[2*WORD_W-1:WORD_W] : '0;
  assign if_id_npc      = if_id_valid ? head[WORD_W-1:0] : '0;
  assign halted         = halted_q;
  assign imem.imem_req  = issue;
  assign imem.imem_addr = pc_q[IMEM_AW-1:0];

  always_comb begin
    redirect = br_taken && (state_q != HALTED);
    rsp      = imem.imem_rvalid && outst_q;
    push     = rsp && !drop_q && !redirect && (state_q != HALTED);
    push_hlt = push && is_hlt(imem.imem_rdata);
    pop      = if_id_valid && id_ready && !redirect;
    pop_hlt  = pop && is_hlt(head[2*WORD_W-1:WORD_W]);
    // Occupancy credits this cycle's pop so latency-1 memory sustains one word per cycle.
    occ      = OCC_W'(count) + OCC_W'(outst_q) - OCC_W'(pop);
    issue    = rst_n && (state_q == RUN) && !hlt_seen_q && !redirect && !push_hlt &&
               (!outst_q || imem.imem_rvalid) && (occ < OCC_W'(DEPTH));

    state_d    = state_q;
    pc_d       = pc_q;
    req_npc_d  = req_npc_q;
    outst_d    = issue ? 1'b1 : (imem.imem_rvalid ? 1'b0 : outst_q);
    drop_d     = (rsp && drop_q) ? 1'b0 : drop_q;
    hlt_seen_d = hlt_seen_q;
    halted_d   = halted_q;

    if (issue) begin
      pc_d      = pc_q + 32'd1;
      req_npc_d = pc_q + 32'd1;
    end

    if (redirect) begin
      pc_d       = br_target;
      hlt_seen_d = 1'b0;
      state_d    = RUN;
      if (outst_q && !imem.imem_rvalid) drop_d = 1'b1;
    end else begin
      if (push_hlt) begin
        hlt_seen_d = 1'b1;
        state_d    = STOP;
      end
      if (pop_hlt) begin
        halted_d = 1'b1;
        state_d  = HALTED;
      end
    end
  end

  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= RUN;
      pc_q       <= RESET_PC;
      req_npc_q  <= '0;
      outst_q    <= 1'b0;
      drop_q     <= 1'b0;
      hlt_seen_q <= 1'b0;
      halted_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      req_npc_q  <= req_npc_d;
      outst_q    <= outst_d;
      drop_q     <= drop_d;
      hlt_seen_q <= hlt_seen_d;
      halted_q   <= halted_d;
    end
  end

endmodule

// File: tb/tb_mips32_fetch_stage.sv
// Self-checking bench for mips32_fetch_stage: cycle vector table plus scoreboarded scenarios.
module tb_mips32_fetch_stage;

  logic        clk1 = 1'b0;
  logic        rst_n = 1'b0;
  logic        br_taken = 1'b0;
  logic [31:0] br_target = 32'h0;
  logic        id_ready = 1'b0;
  logic        if_id_valid;
  logic [31:0] if_id_ir;
  logic [31:0] if_id_npc;
  logic        halted;

  mips32_fetch_stage_if #(.IMEM_AW(10)) m ();

  mips32_fetch_stage #(.RESET_PC(32'h0), .IMEM_AW(10), .DEPTH(2)) dut (
    .clk1        (clk1),
    .rst_n       (rst_n),
    .imem        (m),
    .br_taken    (br_taken),
    .br_target   (br_target),
    .id_ready    (id_ready),
    .if_id_valid (if_id_valid),
    .if_id_ir    (if_id_ir),
    .if_id_npc   (if_id_npc),
    .halted      (halted)
  );

  always #5 clk1 = ~clk1;

  // Instruction memory model with programmable latency, one request in flight.
  logic [31:0] mem [1024];
  int          mem_lat = 1;
  logic        mem_flush = 1'b0;
  logic        pend = 1'b0;
  int          cnt = 0;
  logic [9:0]  paddr = '0;

  always @(posedge clk1) begin
    m.imem_rvalid <= 1'b0;
    if (mem_flush) begin
      pend <= 1'b0;
    end else begin
      if (pend) begin
        if (cnt == 1) begin
          m.imem_rvalid <= 1'b1;
          m.imem_rdata  <= mem[paddr];
          pend          <= 1'b0;
        end else begin
          cnt <= cnt - 1;
        end
      end
      if (m.imem_req) begin
        if (mem_lat == 1) begin
          m.imem_rvalid <= 1'b1;
          m.imem_rdata  <= mem[m.imem_addr];
        end else begin
          pend  <= 1'b1;
          cnt   <= mem_lat - 1;
          paddr <= m.imem_addr;
        end
      end
    end
  end

  typedef struct packed {
    logic        rst;
    logic        rdy;
    logic        req;
    logic [9:0]  addr;
    logic        vld;
    logic [31:0] ir;
    logic [31:0] npc;
  } vec_t;

  typedef struct packed {
    logic [31:0] ir;
    logic [31:0] npc;
  } exp_t;

  vec_t vt [15];
  exp_t sbq [$];
  logic sb_en = 1'b0;
  int   checks = 0;
  int   errors = 0;

  function automatic logic [31:0] wd(input int a);
    return 32'h0155_0000 | (32'(a) & 32'h0000_03FF);
  endfunction

  function automatic vec_t mkv(input logic r, input logic rd, input logic rq, input int ad,
                               input logic v, input logic [31:0] ir, input logic [31:0] npc);
    vec_t x;
    x.rst = r; x.rdy = rd; x.req = rq; x.addr = 10'(ad); x.vld = v; x.ir = ir; x.npc = npc;
    return x;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic sb_push(input logic [31:0] ir, input logic [31:0] npc);
    exp_t e;
    e.ir = ir; e.npc = npc;
    sbq.push_back(e);
  endtask

  task automatic step(input logic rdy, input logic br, input logic [31:0] tgt);
    exp_t e;
    @(negedge clk1);
    id_ready = rdy; br_taken = br; br_target = tgt;
    #1;
    if (sb_en && if_id_valid && rdy && !br) begin
      if (sbq.size() == 0) begin
        checks++; errors++;
        $display("FAIL sb_extra: unexpected ir=%h npc=%h, expected none", if_id_ir, if_id_npc);
      end else begin
        e = sbq.pop_front();
        chk("sb_ir", if_id_ir, e.ir);
        chk("sb_npc", if_id_npc, e.npc);
      end
    end
  endtask

  task automatic do_reset();
    @(negedge clk1);
    rst_n = 1'b0; id_ready = 1'b0; br_taken = 1'b0; mem_flush = 1'b1;
    repeat (2) @(negedge clk1);
    mem_flush = 1'b0;
    @(posedge clk1);
    #1 rst_n = 1'b1;
  endtask

  task automatic drain(input string nm, input int budget);
    int n = 0;
    while (sbq.size() != 0 && n < budget) begin
      step(1'b1, 1'b0, 32'h0);
      n++;
    end
    chk(nm, 32'(sbq.size()), 32'd0);
    sbq.delete();
  endtask

  initial begin
    logic found;
    for (int i = 0; i < 1024; i++) mem[i] = wd(i);

    vt[0]  = mkv(1, 1, 1, 0, 0, 0, 0);
    vt[1]  = mkv(0, 1, 1, 1, 0, 0, 0);
    vt[2]  = mkv(0, 1, 1, 2, 1, wd(0), 1);
    vt[3]  = mkv(0, 1, 1, 3, 1, wd(1), 2);
    vt[4]  = mkv(0, 1, 1, 4, 1, wd(2), 3);
    vt[5]  = mkv(0, 1, 1, 5, 1, wd(3), 4);
    vt[6]  = mkv(1, 0, 1, 0, 0, 0, 0);
    vt[7]  = mkv(0, 0, 1, 1, 0, 0, 0);
    vt[8]  = mkv(0, 0, 0, 2, 1, wd(0), 1);
    vt[9]  = mkv(0, 0, 0, 2, 1, wd(0), 1);
    vt[10] = mkv(0, 0, 0, 2, 1, wd(0), 1);
    vt[11] = mkv(0, 1, 1, 2, 1, wd(0), 1);
    vt[12] = mkv(0, 1, 1, 3, 1, wd(1), 2);
    vt[13] = mkv(0, 1, 1, 4, 1, wd(2), 3);
    vt[14] = mkv(0, 1, 1, 5, 1, wd(3), 4);

    // Reset state
    mem_lat = 1;
    do_reset();
    chk("rst_valid", 32'(if_id_valid), 32'd0);
    chk("rst_ir", if_id_ir, 32'd0);
    chk("rst_npc", if_id_npc, 32'd0);
    chk("rst_halted", 32'(halted), 32'd0);
    chk("rst_addr", 32'(m.imem_addr), 32'd0);

    // Sequential fetch and backpressure, cycle by cycle
    for (int i = 0; i < 15; i++) begin
      if (vt[i].rst) do_reset();
      step(vt[i].rdy, 1'b0, 32'h0);
      chk($sformatf("v%0d_req", i), 32'(m.imem_req), 32'(vt[i].req));
      chk($sformatf("v%0d_addr", i), 32'(m.imem_addr), 32'(vt[i].addr));
      chk($sformatf("v%0d_valid", i), 32'(if_id_valid), 32'(vt[i].vld));
      if (vt[i].vld) begin
        chk($sformatf("v%0d_ir", i), if_id_ir, vt[i].ir);
        chk($sformatf("v%0d_npc", i), if_id_npc, vt[i].npc);
      end
    end

    sb_en = 1'b1;

    // Redirect while addr 5 is outstanding at latency 3
    mem_lat = 3;
    do_reset();
    for (int i = 0; i < 5; i++) sb_push(wd(i), 32'(i + 1));
    sb_push(wd(32'h40), 32'h41);
    sb_push(wd(32'h41), 32'h42);
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      step(1'b1, 1'b0, 32'h0);
      if (m.imem_req && m.imem_addr == 10'd5) found = 1'b1;
    end
    chk("rd_addr5_seen", 32'(found), 32'd1);
    step(1'b1, 1'b0, 32'h0);
    step(1'b1, 1'b1, 32'h40);
    chk("rd_req_blocked", 32'(m.imem_req), 32'd0);
    step(1'b1, 1'b0, 32'h0);
    chk("rd_req_target", 32'(m.imem_req), 32'd1);
    chk("rd_addr_target", 32'(m.imem_addr), 32'h40);
    drain("rd_drain", 40);

    // Halt at address 2
    mem_lat = 1;
    mem[2] = 32'hFC00_0000;
    do_reset();
    sb_push(wd(0), 32'd1);
    sb_push(wd(1), 32'd2);
    sb_push(32'hFC00_0000, 32'd3);
    repeat (3) step(1'b1, 1'b0, 32'h0);
    step(1'b1, 1'b0, 32'h0);
    chk("hlt_no_req", 32'(m.imem_req), 32'd0);
    step(1'b1, 1'b0, 32'h0);
    chk("hlt_not_yet", 32'(halted), 32'd0);
    step(1'b1, 1'b0, 32'h0);
    chk("hlt_halted", 32'(halted), 32'd1);
    chk("hlt_valid", 32'(if_id_valid), 32'd0);
    chk("hlt_req", 32'(m.imem_req), 32'd0);
    step(1'b1, 1'b1, 32'h0);
    step(1'b1, 1'b0, 32'h0);
    chk("hlt_br_ignored", 32'(m.imem_req), 32'd0);
    chk("hlt_sticky", 32'(halted), 32'd1);
    chk("hlt_sb_empty", 32'(sbq.size()), 32'd0);
    sbq.delete();
    mem[2] = wd(2);

    // Wrong-path HLT flushed by a redirect
    mem[1] = 32'hFC00_0000;
    do_reset();
    sb_push(wd(32'h10), 32'h11);
    sb_push(wd(32'h11), 32'h12);
    repeat (3) step(1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b0, 32'h0);
    chk("wp_stop_req", 32'(m.imem_req), 32'd0);
    step(1'b0, 1'b1, 32'h10);
    step(1'b1, 1'b0, 32'h0);
    chk("wp_req", 32'(m.imem_req), 32'd1);
    chk("wp_addr", 32'(m.imem_addr), 32'h10);
    drain("wp_drain", 20);
    chk("wp_not_halted", 32'(halted), 32'd0);
    mem[1] = wd(1);

    // PC wrap at 2^32
    do_reset();
    sb_push(wd(32'h3FF), 32'h0);
    sb_push(wd(0), 32'h1);
    step(1'b1, 1'b1, 32'hFFFF_FFFF);
    chk("wrap_req_blocked", 32'(m.imem_req), 32'd0);
    step(1'b1, 1'b0, 32'h0);
    chk("wrap_addr_top", 32'(m.imem_addr), 32'h3FF);
    step(1'b1, 1'b0, 32'h0);
    chk("wrap_req", 32'(m.imem_req), 32'd1);
    chk("wrap_addr_zero", 32'(m.imem_addr), 32'h0);
    drain("wrap_drain", 20);

    // Reset mid-stall with a response still in flight
    mem_lat = 3;
    do_reset();
    repeat (5) step(1'b0, 1'b0, 32'h0);
    chk("ms_valid_before", 32'(if_id_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("ms_req", 32'(m.imem_req), 32'd0);
    chk("ms_addr", 32'(m.imem_addr), 32'd0);
    chk("ms_valid", 32'(if_id_valid), 32'd0);
    chk("ms_ir", if_id_ir, 32'd0);
    chk("ms_npc", if_id_npc, 32'd0);
    chk("ms_halted", 32'(halted), 32'd0);
    @(posedge clk1);
    @(posedge clk1);
    #1 rst_n = 1'b1;
    sb_push(wd(0), 32'd1);
    sb_push(wd(1), 32'd2);
    step(1'b1, 1'b0, 32'h0);
    chk("ms_restart_req", 32'(m.imem_req), 32'd1);
    chk("ms_restart_addr", 32'(m.imem_addr), 32'd0);
    drain("ms_drain", 40);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mips32_fetch_stage.md
Name: mips32_fetch_stage

Overview:
- IF stage of the 5-stage MIPS32 pipeline. Sits directly upstream of ID and produces the IF/ID latch contents (IR, NPC).
- Owns the PC and issues word-addressed reads to instruction memory with variable latency.
- Buffers fetched words in a small queue so ID stalls do not lose instructions.
- Accepts taken-branch redirects from EX/MEM and stops fetching after an HLT opcode.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- IMEM_AW, 10, instruction memory word-address width (1024 words).
- DEPTH, 2, instruction queue entries. Power of two, at least 2.

Ports:
- clk1  in  1  pipeline clock; all state updates on posedge.
- rst_n  in  1  asynchronous active-low reset.
- imem_req  out  1  read request, one-cycle pulse; memory always accepts it.
- imem_addr  out  IMEM_AW  word address, equal to PC[IMEM_AW-1:0].
- imem_rvalid  in  1  read data valid, at least 1 cycle after imem_req.
- imem_rdata  in  32  instruction word.
- br_taken  in  1  redirect pulse from EX/MEM.
- br_target  in  32  redirect PC (word address).
- id_ready  in  1  ID can accept an instruction this cycle.
- if_id_valid  out  1  queue head is valid.
- if_id_ir  out  32  queue head instruction.
- if_id_npc  out  32  address of queue head + 1.
- halted  out  1  sticky; HLT has been consumed by ID.

Behaviour:
- Reset (async, rst_n=0):
  - pc=RESET_PC; queue empty; no request outstanding; drop flag clear; hlt_seen clear; state RUN.
  - All outputs 0: imem_req, imem_addr, if_id_valid, if_id_ir, if_id_npc, halted.
- States:
  - RUN: fetching. Moves to STOP on a pushed HLT.
  - STOP: HLT fetched, no new requests. Returns to RUN on br_taken. Moves to HALTED when ID accepts the HLT.
  - HALTED: terminal until reset.
- Issue:
  - In RUN, imem_req=1 when no request is outstanding (or imem_rvalid arrives this cycle) and count+outstanding < DEPTH.
  - On issue: req_npc <= pc+1 and pc <= pc+1. PC wraps at 2^32: 32'hFFFF_FFFF -> 0.
  - A new request may issue in the same cycle its predecessor's rvalid arrives.
  - At latency 1 with id_ready=1, throughput is 1 instruction per cycle.
- Response:
  - On imem_rvalid with the drop flag clear, push {imem_rdata, req_npc}.
  - With the drop flag set, discard the data and clear the flag.
  - If the pushed word has opcode [31:26]=6'b111111 (HLT), set hlt_seen and go to STOP.
- Output:
  - if_id_* are driven from the queue head; if_id_valid = count != 0.
  - Pop on if_id_valid & id_ready.
  - Latency from rvalid to if_id_valid is 1 cycle.
  - if_id_ir/npc hold their value while valid & !ready.
- Redirect (br_taken=1, in RUN or STOP):
  - Flush the queue (count=0), pc <= br_target, clear hlt_seen, go to RUN.
  - If a request is outstanding and its rvalid is not this cycle, set the drop flag.
  - A same-cycle rvalid is discarded.
  - Redirect has priority over push, pop and issue in the same cycle.
  - A pop in the same cycle is cancelled: if_id_valid drops to 0 the next cycle.
  - The first request to br_target issues the following cycle.
- Halt:
  - When ID accepts the HLT (pop with head opcode HLT), halted <= 1 and state goes to HALTED.
  - In HALTED: no requests, if_id_valid=0, br_taken ignored.
- Boundaries:
  - Full queue: no issue. Overflow is impossible by the issue rule.
  - Empty queue: if_id_valid=0.
  - Simultaneous push and pop: count unchanged.
  - Reset mid-request: the in-flight response after reset is ignored, because the outstanding flag is cleared and rvalid without outstanding is discarded.

Decomposition:
- Shared package mips32_pkg holds:
  - opcode constants ADD…HLT (HLT=6'b111111);
  - type codes RR_ALU…HALT;
  - OPC_MSB=31, OPC_LSB=26;
  - WORD_W=32.
- One sub-module: mips32_fetch_fifo, a parameterised synchronous DEPTH×64 queue with push, pop, flush, count and head outputs, plus async active-low reset.

Test Plan:
- Sequential fetch: reset, 1-cycle memory, IMEM[0..3]=ADD words, id_ready=1 -> imem_addr 0,1,2,3 on consecutive cycles; if_id_npc 1,2,3,4; first if_id_valid 2 cycles after reset release.
- Backpressure: id_ready=0 from cycle 0 -> exactly 2 requests then imem_req=0; raise id_ready -> words 0,1,2… delivered in order with no loss or duplication.
- Redirect with in-flight request: 3-cycle memory, br_taken with br_target=32'h40 while addr 5 is outstanding -> addr-5 data dropped; next if_id_ir is IMEM[0x40] with npc 0x41.
- Halt: IMEM[2]=32'hFC00_0000 -> no request after addr 2; halted=1 the cycle after ID accepts IR 32'hFC00_0000; a later br_taken produces no imem_req.
- Wrong-path HLT: HLT queued, br_taken to 0x10 before pop -> HLT flushed; fetching resumes at 0x10; halted stays 0.
- Wrap and reset: redirect to 32'hFFFF_FFFF -> npc 32'h0000_0000, next imem_addr 0. Assert rst_n=0 mid-stall -> all outputs 0 immediately; after release, addr RESET_PC fetched.
